cp0_exc_seq: RTL and testbench
==============================

// Module: cp0_exc_seq
// PURPOSE
//  Exception/ERET sequencer that drives the CP0 register block's single write port, trap and eret strobes.
//  Sits at the MEM/WB boundary and does three jobs:
//  - arbitrates the pipeline's MTC0 writes against exception entry, interrupt entry and ERET;
//  - records EPC and BadVAddr over successive cycles;
//  - flushes the pipeline and redirects fetch to the exception vector or to EPC.
// PARAMETERS
//  EXC_VECTOR  32'hBFC00380  fetch target on exception/interrupt entry
//  ADDR_WIDTH  5             CP0 register address width
//  DATA_WIDTH  32            CP0 data width
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  exc_valid      in   1   MEM-stage instruction carries a synchronous exception
//  exc_code       in   5   ExcCode of that exception
//  exc_pc         in   32  PC of the MEM-stage instruction
//  exc_bd         in   1   MEM-stage instruction sits in a branch delay slot
//  exc_has_bva    in   1   exception supplies a bad virtual address (AdEL/AdES)
//  exc_badvaddr   in   32  faulting address
//  eret_req       in   1   MEM-stage instruction is ERET
//  mtc0_req       in   1   MEM-stage MTC0 write request
//  mtc0_addr      in   5   MTC0 target register
//  mtc0_wdata     in   32  MTC0 data
//  mtc0_ready     out  1   MTC0 accepted this cycle
//  int_pending    in   1   |(Cause.IP & Status.IM), from CP0
//  status_ie      in   1   Status.IE
//  status_exl     in   1   Status.EXL
//  epc_value      in   32  current EPC, from CP0
//  cp0_wen        out  1   CP0 write enable
//  cp0_waddr      out  5   CP0 write address
//  cp0_wdata      out  32  CP0 write data
//  cp0_trap       out  1   sets EXL in CP0
//  cp0_eret       out  1   clears EXL in CP0
//  flush          out  1   kill IF..MEM
//  redir_valid    out  1   fetch redirect strobe
//  redir_pc       out  32  fetch redirect target
//  busy           out  1   sequencer active; pipeline stalls
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0 except mtc0_ready.
//    mtc0_ready=1 in IDLE when no higher-priority event is present.
//  - irq = int_pending & status_ie & ~status_exl.
//  - Priority, sampled in IDLE: irq > exc_valid > eret_req > mtc0_req.
//  - MTC0 in IDLE with no event:
//    - combinational pass-through: cp0_wen=1, cp0_waddr=mtc0_addr, cp0_wdata=mtc0_wdata, same cycle;
//    - dropped (mtc0_ready=0) whenever any event wins.
//  - On accept at cycle N, latch:
//    - code (irq -> 5'd0);
//    - epc_l = exc_bd ? exc_pc-4 : exc_pc (32-bit wrap);
//    - bva_l, has_bva_l (forced 0 on irq).
//  - Exception/interrupt FSM:
//    - TRAP (N+1): cp0_trap=1, flush=1.
//    - EPC (N+2): cp0_wen=1, waddr=14, wdata=epc_l. EXL is already set, so CP0 accepts the write.
//    - BVA (N+3, only if has_bva_l): cp0_wen=1, waddr=8, wdata=bva_l.
//    - REDIR (next): redir_valid=1, redir_pc=EXC_VECTOR, flush=1 -> IDLE.
//  - ERET FSM:
//    - ERET (N+1): cp0_eret=1, flush=1, redir_valid=1, redir_pc=epc_value sampled this cycle -> IDLE.
//  - busy=1 in every non-IDLE state. mtc0_ready=0 while busy.
//  - New requests arriving while busy are ignored. The pipeline is stalled and flushed, so none are legal.
//  - Every strobe lasts exactly 1 cycle.
//  - cp0_waddr/cp0_wdata are 0 whenever cp0_wen=0.
//  - Simultaneous exc_valid and eret_req: the exception wins and ERET is discarded.
//  - rst mid-sequence: return to IDLE next edge. No partial write completes after rst.
//  - Back-to-back: a new event may be accepted the cycle after REDIR or ERET.
// STRUCTURE
//  - Shared package cp0_defs: CP0 register numbers (8, 9, 11, 12, 13, 14), ExcCode constants, EXC_VECTOR.
//  - One module. FSM states IDLE, TRAP, EPC, BVA, REDIR, ERET, one-hot localparams.
//  - No sub-module; the write-port mux is inline.
// TESTING
//  1. Idle MTC0: mtc0_req, addr=11, data=32'h100.
//     -> same cycle cp0_wen=1, waddr=11, wdata=32'h100, mtc0_ready=1, busy=0.
//  2. Syscall: exc_valid, code=8, pc=32'hBFC00100, bd=0.
//     -> N+1 trap+flush; N+2 write 14 <- 32'hBFC00100; N+3 redir_pc=32'hBFC00380.
//  3. AdEL in delay slot: pc=32'hBFC00204, bd=1, bva=32'h00000003.
//     -> EPC write 32'hBFC00200; N+3 write 8 <- 32'h00000003; N+4 redirect.
//  4. ERET with epc_value=32'hBFC00200.
//     -> N+1 cp0_eret=1, flush=1, redir_pc=32'hBFC00200; next cycle IDLE.
//  5. Simultaneous irq and mtc0_req, with ie=1, exl=0.
//     -> mtc0_ready=0, no pass-through write, interrupt entry with code 0.
//     Same stimulus with exl=1 -> no entry, MTC0 passes through.
//  6. rst asserted in EPC state.
//     -> next cycle all outputs 0, IDLE. No write 14 and no redirect occur.

Source files
------------

// File: rtl/cp0_exc_seq_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, exception vector
// and the sequencer state encoding.
package cp0_exc_seq_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StTrap  = 6'b000010,
    StEpc   = 6'b000100,
    StBva   = 6'b001000,
    StRedir = 6'b010000,
    StEret  = 6'b100000
  } seq_state_e;

endpackage

// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer owning the CP0 write port, trap/eret strobes,
// pipeline flush and fetch redirect.
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  exc_has_bva,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret_req,
  input  logic                  mtc0_req,
  input  logic [ADDR_WIDTH-1:0] mtc0_addr,
  input  logic [DATA_WIDTH-1:0] mtc0_wdata,
  output logic                  mtc0_ready,
  input  logic                  int_pending,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic [31:0]           epc_value,
  output logic                  cp0_wen,
  output logic [ADDR_WIDTH-1:0] cp0_waddr,
  output logic [DATA_WIDTH-1:0] cp0_wdata,
  output logic                  cp0_trap,
  output logic                  cp0_eret,
  output logic                  flush,
  output logic                  redir_valid,
  output logic [31:0]           redir_pc,
  output logic                  busy
);

  seq_state_e  state_q, state_d;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic [31:0] bva_q;
  logic        has_bva_q;

  logic irq;
  logic take_exc;
  logic unused_code;

  assign irq         = int_pending & status_ie & ~status_exl;
  assign take_exc    = irq | exc_valid;
  // Cause.ExcCode is written by the CP0 block itself; the latched copy is kept for debug.
  assign unused_code = ^code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      code_q    <= '0;
      epc_q     <= '0;
      bva_q     <= '0;
      has_bva_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && take_exc) begin
        code_q    <= irq ? EXC_INT : exc_code;
        epc_q     <= exc_bd ? exc_pc - 32'd4 : exc_pc;
        bva_q     <= irq ? 32'd0 : exc_badvaddr;
        has_bva_q <= irq ? 1'b0 : exc_has_bva;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (take_exc)      state_d = StTrap;
        else if (eret_req) state_d = StEret;
      end
      StTrap:  state_d = StEpc;
      StEpc:   state_d = has_bva_q ? StBva : StRedir;
      StBva:   state_d = StRedir;
      StRedir: state_d = StIdle;
      StEret:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mtc0_ready  = (state_q == StIdle) & ~take_exc & ~eret_req;
    cp0_wen     = 1'b0;
    cp0_waddr   = '0;
    cp0_wdata   = '0;
    cp0_trap    = 1'b0;
    cp0_eret    = 1'b0;
    flush       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    busy        = 1'b0;
    // Reset masks the current state's strobes so no half-finished sequence leaks out.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (mtc0_req && mtc0_ready) begin
            cp0_wen   = 1'b1;
            cp0_waddr = mtc0_addr;
            cp0_wdata = mtc0_wdata;
          end
        end
        StTrap: begin
          cp0_trap = 1'b1;
          flush    = 1'b1;
          busy     = 1'b1;
        end
        StEpc: begin
          cp0_wen   = 1'b1;
          cp0_waddr = ADDR_WIDTH'(CP0_EPC);
          cp0_wdata = DATA_WIDTH'(epc_q);
          busy      = 1'b1;
        end
        StBva: begin
          cp0_wen   = 1'b1;
          cp0_waddr = ADDR_WIDTH'(CP0_BADVADDR);
          cp0_wdata = DATA_WIDTH'(bva_q);
          busy      = 1'b1;
        end
        StRedir: begin
          redir_valid = 1'b1;
          redir_pc    = EXC_VECTOR;
          flush       = 1'b1;
          busy        = 1'b1;
        end
        StEret: begin
          cp0_eret    = 1'b1;
          flush       = 1'b1;
          redir_valid = 1'b1;
          redir_pc    = epc_value;
          busy        = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Scoreboard bench for cp0_exc_seq: each transaction's expected output cycles are
// queued by the driver and popped by a negedge monitor whenever the DUT is active.
module tb_cp0_exc_seq;

  localparam logic [31:0] VEC = 32'hBFC00380;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        trap;
    logic        eret;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        busy;
    logic        ready;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_bd, exc_has_bva, eret_req, mtc0_req;
  logic [4:0]  exc_code, mtc0_addr;
  logic [31:0] exc_pc, exc_badvaddr, mtc0_wdata, epc_value;
  logic        int_pending, status_ie, status_exl;
  logic        mtc0_ready, cp0_wen, cp0_trap, cp0_eret, flush, redir_valid, busy;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata, redir_pc;

  obs_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic chk_ready_en = 1'b0;
  logic chk_ready_exp = 1'b0;
  logic chk_reset = 1'b0;
  logic final_chk = 1'b0;

  always #5 clk = ~clk;

  cp0_exc_seq dut (
    .clk         (clk),
    .rst         (rst),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_bd      (exc_bd),
    .exc_has_bva (exc_has_bva),
    .exc_badvaddr(exc_badvaddr),
    .eret_req    (eret_req),
    .mtc0_req    (mtc0_req),
    .mtc0_addr   (mtc0_addr),
    .mtc0_wdata  (mtc0_wdata),
    .mtc0_ready  (mtc0_ready),
    .int_pending (int_pending),
    .status_ie   (status_ie),
    .status_exl  (status_exl),
    .epc_value   (epc_value),
    .cp0_wen     (cp0_wen),
    .cp0_waddr   (cp0_waddr),
    .cp0_wdata   (cp0_wdata),
    .cp0_trap    (cp0_trap),
    .cp0_eret    (cp0_eret),
    .flush       (flush),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .busy        (busy)
  );

  // Monitor: the only process that counts comparisons.
  always @(negedge clk) begin
    obs_t act, e;
    act = '{wen: cp0_wen, waddr: cp0_waddr, wdata: cp0_wdata, trap: cp0_trap, eret: cp0_eret,
            flush: flush, redir: redir_valid, rpc: redir_pc, busy: busy, ready: mtc0_ready};
    if (chk_reset) begin
      e = '0;
      e.ready = 1'b1;
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL reset_state: got %h want %h", act, e);
      end
    end
    if (chk_ready_en) begin
      vectors++;
      if (mtc0_ready !== chk_ready_exp) begin
        miscompares++;
        $display("FAIL mtc0_ready: got %b want %b", mtc0_ready, chk_ready_exp);
      end
    end
    vectors++;
    if (cp0_wen !== 1'b1 && (cp0_waddr !== 5'd0 || cp0_wdata !== 32'd0)) begin
      miscompares++;
      $display("FAIL idle_wport: got waddr=%h wdata=%h want 0", cp0_waddr, cp0_wdata);
    end
    if (cp0_wen === 1'b1 || cp0_trap === 1'b1 || cp0_eret === 1'b1 || redir_valid === 1'b1 ||
        flush === 1'b1 || busy === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_activity: got %h want none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL output_cycle: got %h want %h", act, e);
        end
      end
    end
    if (final_chk) begin
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
    end
  end

  task automatic clear_inputs();
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_has_bva = 0; exc_badvaddr = 0;
    eret_req = 0; mtc0_req = 0; mtc0_addr = 0; mtc0_wdata = 0; int_pending = 0;
    status_ie = 0; status_exl = 0; epc_value = 0;
    chk_ready_en = 0; chk_reset = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  // One request in IDLE; the reference model lists the output cycles it must produce.
  task automatic txn(input logic ip, input logic ie, input logic exl, input logic ev,
                     input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic hb, input logic [31:0] bva, input logic er,
                     input logic [31:0] epcv, input logic mr, input logic [4:0] ma,
                     input logic [31:0] md, input bit rst_in_epc);
    obs_t e;
    logic irq;
    int   len;
    @(posedge clk); #1;
    clear_inputs();
    int_pending = ip; status_ie = ie; status_exl = exl;
    exc_valid = ev; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_has_bva = hb; exc_badvaddr = bva; eret_req = er; epc_value = epcv;
    mtc0_req = mr; mtc0_addr = ma; mtc0_wdata = md;
    irq = ip & ie & ~exl;
    chk_ready_en = 1; chk_ready_exp = !(irq || ev || er);
    len = 0;
    if (irq || ev) begin
      e = '0; e.trap = 1; e.flush = 1; e.busy = 1;
      exp_q.push_back(e);
      len = 1;
      if (!rst_in_epc) begin
        e = '0; e.wen = 1; e.waddr = 5'd14; e.wdata = bd ? pc - 32'd4 : pc; e.busy = 1;
        exp_q.push_back(e);
        if (hb && !irq) begin
          e = '0; e.wen = 1; e.waddr = 5'd8; e.wdata = bva; e.busy = 1;
          exp_q.push_back(e);
        end
        e = '0; e.redir = 1; e.rpc = VEC; e.flush = 1; e.busy = 1;
        exp_q.push_back(e);
        len = (hb && !irq) ? 4 : 3;
      end
    end else if (er) begin
      e = '0; e.eret = 1; e.flush = 1; e.redir = 1; e.rpc = epcv; e.busy = 1;
      exp_q.push_back(e);
      len = 1;
    end else if (mr) begin
      e = '0; e.wen = 1; e.waddr = ma; e.wdata = md; e.ready = 1;
      exp_q.push_back(e);
    end
    // While busy, throw illegal requests at it; they must all be ignored.
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      chk_ready_en = 1; chk_ready_exp = 0;
      int_pending = 1'($urandom); status_ie = 1; status_exl = 0;
      exc_valid = 1'($urandom); eret_req = 1'($urandom); mtc0_req = 1'($urandom);
      mtc0_addr = 5'($urandom); mtc0_wdata = $urandom; exc_pc = $urandom;
      exc_has_bva = 1'($urandom); exc_badvaddr = $urandom;
    end
    if (rst_in_epc) begin
      @(posedge clk); #1;
      rst = 1;
      chk_ready_en = 0;
      @(posedge clk); #1;
      rst = 0;
      clear_inputs();
      chk_reset = 1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset = 0;
    idle(1);
    // 1. idle MTC0 pass-through
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 32'h100, 0);
    idle(1);
    // 2. syscall
    txn(0, 0, 0, 1, 5'd8, 32'hBFC00100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // 3. AdEL in delay slot
    txn(0, 0, 0, 1, 5'd4, 32'hBFC00204, 1, 1, 32'h3, 0, 0, 0, 0, 0, 0);
    idle(1);
    // 4. ERET
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBFC00200, 0, 0, 0, 0);
    // back-to-back: 5. irq beats MTC0, then masked by EXL
    txn(1, 1, 0, 0, 0, 32'hBFC00400, 0, 1, 32'hDEAD, 0, 0, 1, 5'd12, 32'h55, 0);
    txn(1, 1, 1, 0, 0, 32'hBFC00400, 0, 1, 32'hDEAD, 0, 0, 1, 5'd12, 32'h55, 0);
    idle(1);
    // exception beats simultaneous ERET; PC wrap in delay slot
    txn(0, 0, 0, 1, 5'd12, 32'h0000_0002, 1, 0, 0, 1, 32'h1234, 1, 5'd9, 32'h77, 0);
    idle(1);
    // 6. reset while in EPC state
    txn(0, 0, 0, 1, 5'd8, 32'hBFC00100, 0, 1, 32'h44, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int n = 0; n < 250; n++) begin
      txn(($urandom % 3) == 0, 1'($urandom), 1'($urandom), ($urandom % 3) == 0,
          5'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
          ($urandom % 3) == 0, $urandom, 1'($urandom), 5'($urandom), $urandom, 0);
      idle($urandom_range(0, 2));
    end
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    final_chk = 1;
    @(negedge clk);
    #1;
    final_chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
